// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-channel select multiplexer.
package mux_pkg;

    // Values of the mode input.
    localparam logic MODE_ADDRESSED   = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    // The output holding register is either empty or holds one word.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

endpackage : mux_pkg

// File: rtl/rr_picker.sv
// Combinational rotating-priority selector: the first asserted request at or after ptr wins.
module rr_picker #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ADDR_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [ADDR_W-1:0]   ptr,
    output logic                grant_valid,
    output logic [ADDR_W-1:0]   grant_idx
);

    logic [ADDR_W-1:0] scan_idx;

    // Scan ptr, ptr+1, ... ; CHANNELS is a power of two so ADDR_W arithmetic wraps for free.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            scan_idx = ptr + ADDR_W'(k);
            if (!grant_valid && req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

endmodule : rr_picker

// File: rtl/channel_select_mux.sv
// Registered N:1 channel multiplexer with valid/ready on every input and on the output.
// Supports addressed selection and round-robin arbitration.
module channel_select_mux
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned ADDR_W  = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mode,
    input  logic [ADDR_W-1:0]         address,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [ADDR_W-1:0]         out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  out_data_q;
    logic [ADDR_W-1:0] out_channel_q;
    logic [ADDR_W-1:0] rr_ptr_q;

    logic              rr_grant_valid;
    logic [ADDR_W-1:0] rr_grant_idx;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_idx;
    logic [WIDTH-1:0]  sel_word;
    logic              can_load;
    logic              in_xfer;
    logic              out_xfer;

    rr_picker #(
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W)
    ) u_rr_picker (
        .req         (in_valid),
        .ptr         (rr_ptr_q),
        .grant_valid (rr_grant_valid),
        .grant_idx   (rr_grant_idx)
    );

    assign out_valid = (state_q == StFull);
    assign out_xfer  = out_valid && out_ready;
    // A new word may enter when the register is empty or is being drained this cycle.
    assign can_load  = !out_valid || out_ready;

    // Mode mux: pick the candidate channel and whether it may be granted.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (mode == MODE_ROUND_ROBIN) begin
            sel_valid = rr_grant_valid;
            sel_idx   = rr_grant_idx;
        end else begin
            // An idle addressed channel blocks the grant even if others are valid.
            sel_valid = in_valid[address];
            sel_idx   = address;
        end
    end

    // One-hot ready to the granted channel only; held low while in reset.
    always_comb begin
        in_ready = '0;
        if (reset_n && can_load && sel_valid) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    assign in_xfer = |(in_valid & in_ready);

    // Extract the granted channel's word from the packed input bus.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (ADDR_W'(i) == sel_idx) begin
                sel_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic for the output register occupancy.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // Simultaneous drain and load keeps the register full.
                if (out_xfer && !in_xfer) begin
                    state_d = StEmpty;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Output holding register; loads only on an input transfer, otherwise stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else if (in_xfer) begin
            out_data_q    <= sel_word;
            out_channel_q <= sel_idx;
        end
    end

    // Round-robin pointer moves past the winner; addressed transfers leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (in_xfer && (mode == MODE_ROUND_ROBIN)) begin
            rr_ptr_q <= sel_idx + ADDR_W'(1);
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule : channel_select_mux
